cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, default 8, tag field width (bits 39:32 of a bus word).
REQ-002 Parameter DATA_W, default 32, data field width (bits 31:0 of a bus word).
REQ-003 Parameter FIFO_DEPTH, default 2, entries per requester FIFO.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 add_valid / add_data / add_ready  in/in/out  1/40/1  adder result handshake; {tag,data}.
REQ-007 mult_valid / mult_data / mult_ready  in/in/out  1/40/1  multiplier result handshake.
REQ-008 load_valid / load_data / load_ready  in/in/out  1/40/1  load unit result handshake.
REQ-009 cdb_valid  output  1  broadcast word valid this cycle.
REQ-010 cdb_out  output  40  broadcast {tag,data}; feeds addbus/multbus/loadbus consumers.
REQ-011 cdb_src  output  2  source of cdb_out: 0 add, 1 mult, 2 load.
REQ-012 tag0_err  output  1  sticky flag: a word with tag 0 was offered.

Function
REQ-013 Each requester SHALL own a FIFO_DEPTH-entry FIFO; *_ready = FIFO not full, purely registered state, no combinational path from any valid.
REQ-014 Transfer occurs when valid && ready at posedge; word written to FIFO tail that edge.
REQ-015 A word with tag field 0 SHALL be accepted, discarded (not enqueued), and set tag0_err.
REQ-016 Each cycle the arbiter SHALL select one non-empty FIFO by round-robin, searching from rr_ptr upward mod 3.
REQ-017 At posedge the selected head SHALL be popped into the cdb_out register, cdb_valid<=1, cdb_src<=index, rr_ptr<=(index+1) mod 3.
REQ-018 No FIFO non-empty: cdb_valid<=0, cdb_out<=0, cdb_src<=0, rr_ptr unchanged.
REQ-019 Latency: valid offered and accepted at edge E0 -> earliest cdb_valid visible after edge E1 (one cycle later); no bypass of empty FIFO.
REQ-020 Push and pop of the same FIFO on one edge SHALL both take effect; count unchanged.
REQ-021 Full FIFO: ready=0; offered word held by requester, never dropped or overwritten.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order per source strictly FIFO.
REQ-023 Bound: with all three sources continuously backlogged, each source SHALL be granted exactly once every 3 cycles.
REQ-024 cdb_out SHALL hold one word for exactly one cycle per grant; duplicate broadcast forbidden.

Reset
REQ-025 rst_n low SHALL immediately clear all FIFOs, cdb_valid=0, cdb_out=0, cdb_src=0, rr_ptr=0, tag0_err=0; all *_ready=1 after release.
REQ-026 Reset mid-operation SHALL discard all queued words without broadcasting them.
REQ-027 tag0_err SHALL clear only on reset.

Structure
REQ-028 Shared package cdb_pkg SHALL hold TAG_W, DATA_W, BUS_W=40, TAG_NONE=0, source indices SRC_ADD=0, SRC_MULT=1, SRC_LOAD=2.
REQ-029 One sub-module cdb_fifo (parameterised depth/width, push/pop/full/empty/head), instantiated three times; arbiter and output register in cdb_arbiter.

Verification
REQ-030 Single: add offers {8'h03,32'h0000_0010} at E0 -> after E1 cdb_valid=1, cdb_out=40'h03_0000_0010, cdb_src=0; next cycle cdb_valid=0.
REQ-031 Simultaneous: add tag 1, mult tag 2, load tag 3 at E0 from reset -> broadcasts tag 1,2,3 on consecutive cycles, cdb_src 0,1,2.
REQ-032 Backpressure: load offers 4 words, no pops possible (add/mult backlogged) -> load_ready=0 after 2 accepts; all 4 eventually broadcast in order.
REQ-033 Fairness: all three valid continuously 30 cycles -> 10 grants each, pattern 0,1,2 repeating.
REQ-034 Tag 0: mult offers {8'h00,32'hDEAD_BEEF} -> no broadcast, tag0_err=1 until reset.
REQ-035 Reset mid-run: 3 queued words, rst_n low one cycle -> cdb_valid=0 at once, no queued word appears after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants, payload layout and helpers for the common data bus arbiter.
package cdb_pkg;

  localparam int unsigned TAG_W    = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BUS_W    = 40;
  localparam int unsigned TAG_NONE = 0;

  localparam int unsigned NUM_SRC  = 3;
  localparam int unsigned SRC_W    = 2;

  localparam logic [SRC_W-1:0] SRC_ADD  = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MULT = 2'd1;
  localparam logic [SRC_W-1:0] SRC_LOAD = 2'd2;

  // One broadcast word as seen on any result bus.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_word_t;

  // Next source index in round-robin order, wrapping after the load unit.
  function automatic logic [SRC_W-1:0] src_next(input logic [SRC_W-1:0] src);
    return (src >= SRC_LOAD) ? SRC_ADD : src + SRC_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshakes from the three execution units plus the broadcast bus.
interface cdb_arbiter_if #(
  parameter int unsigned TAG_W  = cdb_pkg::TAG_W,
  parameter int unsigned DATA_W = cdb_pkg::DATA_W
);

  localparam int unsigned BUS_W = TAG_W + DATA_W;

  logic             add_valid;
  logic [BUS_W-1:0] add_data;
  logic             add_ready;

  logic             mult_valid;
  logic [BUS_W-1:0] mult_data;
  logic             mult_ready;

  logic             load_valid;
  logic [BUS_W-1:0] load_data;
  logic             load_ready;

  logic             cdb_valid;
  logic [BUS_W-1:0] cdb_out;
  logic [1:0]       cdb_src;
  logic             tag0_err;

  // Requester side: execution units and broadcast consumers.
  modport master (
    output add_valid, add_data,
    output mult_valid, mult_data,
    output load_valid, load_data,
    input  add_ready, mult_ready, load_ready,
    input  cdb_valid, cdb_out, cdb_src, tag0_err
  );

  // Arbiter side.
  modport slave (
    input  add_valid, add_data,
    input  mult_valid, mult_data,
    input  load_valid, load_data,
    output add_ready, mult_ready, load_ready,
    output cdb_valid, cdb_out, cdb_src, tag0_err
  );

endinterface

// File: rtl/cdb_fifo.sv
// Small per-requester FIFO with registered full/empty flags.
module cdb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             push_en;
  logic             pop_en;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count;
    case ({push_en, pop_en})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and the flags derived from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging add/mult/load results onto one common data bus.
module cdb_arbiter #(
  parameter int unsigned TAG_W      = cdb_pkg::TAG_W,
  parameter int unsigned DATA_W     = cdb_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cdb_arbiter_if.slave    bus
);

  import cdb_pkg::NUM_SRC;
  import cdb_pkg::SRC_W;
  import cdb_pkg::SRC_ADD;
  import cdb_pkg::SRC_MULT;
  import cdb_pkg::SRC_LOAD;
  import cdb_pkg::TAG_NONE;
  import cdb_pkg::src_next;

  localparam int unsigned BUS_W = TAG_W + DATA_W;

  logic [NUM_SRC-1:0] in_valid;
  logic [BUS_W-1:0]   in_data [NUM_SRC];
  logic [BUS_W-1:0]   head    [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] tag_zero;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               discard;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;

  logic [SRC_W-1:0]   rr_ptr;
  logic               cdb_valid_q;
  logic [BUS_W-1:0]   cdb_out_q;
  logic [SRC_W-1:0]   cdb_src_q;
  logic               tag0_err_q;

  assign in_valid[SRC_ADD]  = bus.add_valid;
  assign in_valid[SRC_MULT] = bus.mult_valid;
  assign in_valid[SRC_LOAD] = bus.load_valid;
  assign in_data[SRC_ADD]   = bus.add_data;
  assign in_data[SRC_MULT]  = bus.mult_data;
  assign in_data[SRC_LOAD]  = bus.load_data;

  // Ready is the inverse of a registered full flag, so no valid-to-ready path exists.
  assign bus.add_ready  = ~full[SRC_ADD];
  assign bus.mult_ready = ~full[SRC_MULT];
  assign bus.load_ready = ~full[SRC_LOAD];

  // Accepted words are queued unless they carry the reserved tag, which is dropped.
  always_comb begin
    tag_zero = '0;
    push     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tag_zero[i] = (in_data[i][BUS_W-1:DATA_W] == TAG_W'(TAG_NONE));
      push[i]     = in_valid[i] & ~full[i] & ~tag_zero[i];
    end
    discard = |(in_valid & ~full & tag_zero);
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BUS_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (in_data[g]),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // First non-empty FIFO at or after rr_ptr wins; the winner's head is popped.
  always_comb begin
    logic [SRC_W-1:0] cur;
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    pop         = '0;
    cur         = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_found && !empty[cur]) begin
        grant_found = 1'b1;
        grant_idx   = cur;
      end
      cur = src_next(cur);
    end
    if (grant_found) pop[grant_idx] = 1'b1;
  end

  // Broadcast register: one word per grant, cleared whenever nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_out_q   <= '0;
      cdb_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (grant_found) begin
      cdb_valid_q <= 1'b1;
      cdb_out_q   <= head[grant_idx];
      cdb_src_q   <= grant_idx;
      rr_ptr      <= src_next(grant_idx);
    end else begin
      cdb_valid_q <= 1'b0;
      cdb_out_q   <= '0;
      cdb_src_q   <= '0;
    end
  end

  // Sticky reserved-tag flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag0_err_q <= 1'b0;
    end else if (discard) begin
      tag0_err_q <= 1'b1;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_out   = cdb_out_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.tag0_err  = tag0_err_q;

  a_onehot_pop: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop));
  a_src_range: assert property (@(posedge clk) disable iff (!rst_n) cdb_src_q <= SRC_LOAD);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, a round-robin pointer, and the broadcast word.
  logic [39:0] m_q [3][$];
  int          m_rr = 0;
  bit          m_valid = 0;
  logic [39:0] m_out = '0;
  int          m_src = 0;
  bit          m_err = 0;

  task automatic model_clear();
    for (int s = 0; s < 3; s++) m_q[s].delete();
    m_rr = 0; m_valid = 0; m_out = '0; m_src = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [39:0] din [3];
    bit vin [3];
    bit acc [3];
    int sel;
    vin[0] = bus.add_valid;  din[0] = bus.add_data;
    vin[1] = bus.mult_valid; din[1] = bus.mult_data;
    vin[2] = bus.load_valid; din[2] = bus.load_data;
    for (int s = 0; s < 3; s++) acc[s] = vin[s] && (m_q[s].size() < DEPTH);
    sel = -1;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (sel < 0 && m_q[s].size() > 0) sel = s;
    end
    if (sel >= 0) begin
      m_out = m_q[sel].pop_front();
      m_valid = 1; m_src = sel; m_rr = (sel + 1) % 3;
    end else begin
      m_out = '0; m_valid = 0; m_src = 0;
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) begin
        if (din[s][39:32] == 8'h00) m_err = 1;
        else m_q[s].push_back(din[s]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_clear();
    else model_step();
  end

  // Every falling edge: all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check("cdb_out", 64'(bus.cdb_out), 64'(m_out));
    check("cdb_src", 64'(bus.cdb_src), 64'(m_src));
    check("tag0_err", 64'(bus.tag0_err), 64'(m_err));
    check("add_ready", 64'(bus.add_ready), 64'(m_q[0].size() < DEPTH));
    check("mult_ready", 64'(bus.mult_ready), 64'(m_q[1].size() < DEPTH));
    check("load_ready", 64'(bus.load_ready), 64'(m_q[2].size() < DEPTH));
  end

  // Requester behaviour: each source holds its head word until it is accepted.
  logic [39:0] pend [3][$];
  bit          drv_valid [3];
  logic [39:0] drv_data [3];
  bit          ready_seen [3];

  function automatic bit ready_of(input int s);
    case (s)
      0: return bus.add_ready;
      1: return bus.mult_ready;
      default: return bus.load_ready;
    endcase
  endfunction

  task automatic apply_inputs();
    bus.add_valid  = drv_valid[0]; bus.add_data  = drv_data[0];
    bus.mult_valid = drv_valid[1]; bus.mult_data = drv_data[1];
    bus.load_valid = drv_valid[2]; bus.load_data = drv_data[2];
  endtask

  task automatic drive_clear();
    for (int s = 0; s < 3; s++) begin
      pend[s].delete();
      drv_valid[s] = 0; drv_data[s] = '0; ready_seen[s] = 0;
    end
    apply_inputs();
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (drv_valid[s] && ready_seen[s]) void'(pend[s].pop_front());
      ready_seen[s] = ready_of(s);
    end
    for (int s = 0; s < 3; s++) begin
      drv_valid[s] = (pend[s].size() > 0);
      drv_data[s]  = drv_valid[s] ? pend[s][0] : 40'h0;
    end
    apply_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    drive_clear();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [39:0] rand_word();
    logic [7:0] tag;
    tag = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return {tag, 32'($urandom)};
  endfunction

  task automatic random_phase(input int cycles, input int rate);
    for (int c = 0; c < cycles; c++) begin
      for (int s = 0; s < 3; s++)
        if (pend[s].size() < 2 && $urandom_range(0, 99) < rate) pend[s].push_back(rand_word());
      drive_cycle();
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [39:0] load_words [4];
    logic [39:0] seen [$];
    int src_cnt [3];
    int pat_bad;
    int valid_bad;
    int bcast;

    drive_clear();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset state.
    @(negedge clk); #1;
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_out", 64'(bus.cdb_out), 64'd0);
    check("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    check("rst_tag0_err", 64'(bus.tag0_err), 64'd0);
    check("rst_readies", 64'({bus.add_ready, bus.mult_ready, bus.load_ready}), 64'd7);

    // Single word: visible one cycle after acceptance, then gone.
    pend[0].push_back(40'h03_0000_0010);
    drive_cycle();
    drive_cycle();
    check("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    drive_cycle();
    check("single_valid", 64'(bus.cdb_valid), 64'd1);
    check("single_out", 64'(bus.cdb_out), 64'h03_0000_0010);
    check("single_src", 64'(bus.cdb_src), 64'd0);
    check("single_model_out", 64'(m_out), 64'h03_0000_0010);
    drive_cycle();
    check("single_once", 64'(bus.cdb_valid), 64'd0);

    // Simultaneous offers from reset: tags 1,2,3 from sources 0,1,2.
    do_reset();
    pend[0].push_back(40'h01_1111_1111);
    pend[1].push_back(40'h02_2222_2222);
    pend[2].push_back(40'h03_3333_3333);
    drive_cycle();
    drive_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      check("simul_valid", 64'(bus.cdb_valid), 64'd1);
      check("simul_tag", 64'(bus.cdb_out[39:32]), 64'(i + 1));
      check("simul_src", 64'(bus.cdb_src), 64'(i));
    end
    drive_cycle();
    check("simul_idle", 64'(bus.cdb_valid), 64'd0);

    // Backpressure on load while add and mult stay backlogged.
    do_reset();
    load_words[0] = 40'h41_0000_0001;
    load_words[1] = 40'h42_0000_0002;
    load_words[2] = 40'h43_0000_0003;
    load_words[3] = 40'h44_0000_0004;
    for (int i = 0; i < 6; i++) begin
      pend[0].push_back({8'h10 + 8'(i), 32'hA000_0000 + 32'(i)});
      pend[1].push_back({8'h20 + 8'(i), 32'hB000_0000 + 32'(i)});
    end
    for (int i = 0; i < 4; i++) pend[2].push_back(load_words[i]);
    seen.delete();
    drive_cycle();
    drive_cycle();
    check("bp_ready_after_1", 64'(bus.load_ready), 64'd1);
    drive_cycle();
    check("bp_ready_after_2", 64'(bus.load_ready), 64'd0);
    if (bus.cdb_valid && bus.cdb_src == 2'd2) seen.push_back(bus.cdb_out);
    for (int c = 0; c < 25; c++) begin
      drive_cycle();
      if (bus.cdb_valid && bus.cdb_src == 2'd2) seen.push_back(bus.cdb_out);
    end
    check("bp_load_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("bp_load_order", (i < seen.size()) ? 64'(seen[i]) : 64'hFFFF, 64'(load_words[i]));

    // Fairness: all sources continuously backlogged for 30 broadcast cycles.
    do_reset();
    for (int i = 0; i < 40; i++)
      for (int s = 0; s < 3; s++) pend[s].push_back({8'(s * 64 + i + 1), 32'(i)});
    drive_cycle();
    drive_cycle();
    pat_bad = 0; valid_bad = 0;
    for (int s = 0; s < 3; s++) src_cnt[s] = 0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle();
      if (!bus.cdb_valid) valid_bad++;
      else src_cnt[bus.cdb_src]++;
      if (32'(bus.cdb_src) != 32'(c % 3)) pat_bad++;
    end
    check("fair_all_valid", 64'(valid_bad), 64'd0);
    check("fair_pattern", 64'(pat_bad), 64'd0);
    check("fair_add", 64'(src_cnt[0]), 64'd10);
    check("fair_mult", 64'(src_cnt[1]), 64'd10);
    check("fair_load", 64'(src_cnt[2]), 64'd10);

    // Reserved tag: discarded, sticky error until reset.
    do_reset();
    pend[1].push_back(40'h00_DEAD_BEEF);
    drive_cycle();
    bcast = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle();
      if (bus.cdb_valid) bcast++;
    end
    check("tag0_no_bcast", 64'(bcast), 64'd0);
    check("tag0_err_set", 64'(bus.tag0_err), 64'd1);
    check("tag0_model", 64'(m_err), 64'd1);
    do_reset();
    drive_cycle();
    check("tag0_err_cleared", 64'(bus.tag0_err), 64'd0);

    // Reset mid-run with three words queued.
    do_reset();
    pend[0].push_back(40'h51_0000_0001);
    pend[0].push_back(40'h52_0000_0002);
    pend[1].push_back(40'h61_0000_0001);
    pend[2].push_back(40'h71_0000_0001);
    drive_cycle();
    drive_cycle();
    drive_cycle();
    check("midrst_before", 64'(bus.cdb_out), 64'h51_0000_0001);
    #2 rst_n = 1'b0;
    drive_clear();
    #1;
    check("midrst_valid_now", 64'(bus.cdb_valid), 64'd0);
    check("midrst_out_now", 64'(bus.cdb_out), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    bcast = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle();
      if (bus.cdb_valid) bcast++;
    end
    check("midrst_no_replay", 64'(bcast), 64'd0);

    // Random traffic at several load levels, with a reset in the middle.
    do_reset();
    random_phase(300, 30);
    random_phase(300, 95);
    do_reset();
    random_phase(300, 60);
    for (int s = 0; s < 3; s++) pend[s].delete();
    repeat (10) drive_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
